// File: rtl/seq_chunk_adder.sv
// seq_chunk_adder: multi-cycle add/subtract that processes CHUNK bits per clock.
// A registered carry links the chunks, and valid/ready handshakes sit on both sides.
module seq_chunk_adder #(
  parameter int WIDTH = 32,
  parameter int CHUNK = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] A,
  input  logic [WIDTH-1:0] B,
  input  logic             Cin,
  input  logic             Sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] Sum,
  output logic             Cout,
  output logic             Ovf,
  output logic             busy
);

  localparam int NCHUNK = WIDTH / CHUNK;
  localparam int CW     = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
  localparam logic [CW-1:0] LAST_CHUNK = CW'(NCHUNK - 1);

  if ((WIDTH % CHUNK) != 0) begin : g_bad_chunk
    $error("seq_chunk_adder: WIDTH must be a multiple of CHUNK");
  end

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  state_t            state_s;
  logic              accept_s;
  logic              step_s;
  logic              last_s;

  logic [WIDTH-1:0]  a_r;
  logic [WIDTH-1:0]  b_r;
  logic              carry_r;
  logic [CW-1:0]     cnt_r;
  logic [WIDTH-1:0]  sum_r;
  logic              cout_r;
  logic              ovf_r;
  logic              in_ready_r;
  logic              out_valid_r;
  logic              busy_r;

  logic [31:0]       shift_s;
  logic [CHUNK-1:0]  a_k_s;
  logic [CHUNK-1:0]  b_k_s;
  logic [CHUNK:0]    add_s;
  logic [WIDTH-1:0]  mask_s;
  logic [WIDTH-1:0]  sum_next_s;
  logic              msb_cin_s;

  function automatic logic [CHUNK:0] chunk_add(input logic [CHUNK-1:0] x,
                                               input logic [CHUNK-1:0] y,
                                               input logic             c);
    chunk_add = {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
  endfunction

  // Carry into a bit position, recovered from the sum bit since s = x ^ y ^ cin.
  function automatic logic carry_into(input logic x, input logic y, input logic s);
    carry_into = x ^ y ^ s;
  endfunction

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Next-state decode and per-cycle datapath strobes.
  always_comb begin
    state_s  = state_r;
    accept_s = 1'b0;
    step_s   = 1'b0;
    last_s   = 1'b0;
    case (state_r)
      IDLE: begin
        if (in_valid) begin
          accept_s = 1'b1;
          state_s  = RUN;
        end else begin
          state_s  = IDLE;
        end
      end
      RUN: begin
        step_s = 1'b1;
        if (cnt_r == LAST_CHUNK) begin
          last_s  = 1'b1;
          state_s = DONE;
        end else begin
          state_s = RUN;
        end
      end
      DONE: begin
        if (out_ready) begin
          state_s = IDLE;
        end else begin
          state_s = DONE;
        end
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // Chunk select, chunk add and merge of the chunk result into the running sum.
  always_comb begin
    shift_s    = 32'(cnt_r) * 32'(CHUNK);
    a_k_s      = CHUNK'(a_r >> shift_s);
    b_k_s      = CHUNK'(b_r >> shift_s);
    add_s      = chunk_add(a_k_s, b_k_s, carry_r);
    mask_s     = WIDTH'({CHUNK{1'b1}}) << shift_s;
    sum_next_s = (sum_r & ~mask_s) | (WIDTH'(add_s[CHUNK-1:0]) << shift_s);
    msb_cin_s  = carry_into(a_k_s[CHUNK-1], b_k_s[CHUNK-1], add_s[CHUNK-1]);
  end

  // Operand capture, carry chain register, chunk counter and result registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      a_r     <= '0;
      b_r     <= '0;
      carry_r <= 1'b0;
      cnt_r   <= '0;
      sum_r   <= '0;
      cout_r  <= 1'b0;
      ovf_r   <= 1'b0;
    end else if (accept_s) begin
      // Subtraction is A + ~B + 1; Cin is deliberately dropped in that mode.
      a_r     <= A;
      b_r     <= Sub ? ~B : B;
      carry_r <= Sub ? 1'b1 : Cin;
      cnt_r   <= '0;
    end else if (step_s) begin
      sum_r   <= sum_next_s;
      carry_r <= add_s[CHUNK];
      cnt_r   <= cnt_r + CW'(1);
      if (last_s) begin
        cout_r <= add_s[CHUNK];
        ovf_r  <= msb_cin_s ^ add_s[CHUNK];
      end
    end
  end

  // Handshake and status flags registered from the next state.
  always_ff @(posedge clk) begin
    if (rst) begin
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      busy_r      <= 1'b0;
    end else begin
      in_ready_r  <= (state_s == IDLE);
      out_valid_r <= (state_s == DONE);
      busy_r      <= (state_s != IDLE);
    end
  end

  assign in_ready  = in_ready_r;
  assign out_valid = out_valid_r;
  assign busy      = busy_r;
  assign Sum       = sum_r;
  assign Cout      = cout_r;
  assign Ovf       = ovf_r;

endmodule
